bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble). It sits downstream of the seconds-driven binary counter and feeds per-digit BCD nibbles to the hex7seg digit drivers, so decimal counts display correctly. It runs on the master clock and converts one value per start request.

Parameters:
WIDTH, 8, bit width of the binary input.
DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1; an invalid combination is an elaboration error.

Ports:
mclk  input  1  master clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  conversion request; sampled only in IDLE.
bin  input  WIDTH  binary value; captured on the edge that accepts start.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bcd is updated.
bcd  output  4*DIGITS  result; digit i occupies bits [4i+3:4i], digit 0 is the least significant.

Behaviour:
- Reset: on a rising edge with reset=1:
  - state goes to IDLE; bcd=0, busy=0, done=0.
  - Shift and scratch registers and the iteration counter are cleared.
  - reset takes priority over every other input, including mid-conversion; the conversion in progress is aborted and no done pulse is issued.
- FSM states: IDLE and SHIFT.
- IDLE:
  - On an edge with start=1, capture bin into the shift register, clear the BCD scratch, load the counter with WIDTH, and go to SHIFT.
  - busy goes to 1 on that same edge.
- SHIFT, one iteration per cycle:
  - For every scratch digit >= 5, add 3.
  - Then shift {scratch, shift register} left by 1 and decrement the counter.
- Completion: on the edge that performs iteration WIDTH:
  - Copy scratch into bcd and register done=1.
  - Register busy=0 and return to IDLE.
- Latency: start accepted at edge E0 gives bcd valid and done=1 in the cycle after edge E0+WIDTH (8 cycles for the default).
- done: high for exactly one cycle per completed conversion.
- bcd: holds its last result until the next completion or reset; it never shows intermediate scratch values.
- start while busy=1 is ignored. It is not queued and causes no error.
- Back-to-back: start=1 in the cycle where done=1 is accepted (state is IDLE), so the minimum spacing between conversions is WIDTH+1 cycles.
- Input changes on bin after acceptance have no effect on the conversion in progress.
- start held high continuously gives repeated conversions every WIDTH+1 cycles.
- Per-digit add-3 logic must be generated from DIGITS; no hard-coded digit count.

Optional Feature:
- Macro name: LEADING_ZERO_BLANK_EN.
- When defined:
  - Adds output port blank, width DIGITS, registered and updated on the same edge as bcd.
  - blank[i]=1 when digit i and all higher digits are zero.
  - blank[0] is always 0, so the value 0 shows a single "0".
  - Reset value of blank is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Default params: reset, then bin=8'd255, start pulse -> done exactly 8 cycles after acceptance; bcd=12'h255; busy high for 8 cycles.
- bin=0, then bin=99, then bin=100 as separate requests -> bcd=12'h000, 12'h099, 12'h100 respectively. With LEADING_ZERO_BLANK_EN, blank=3'b110, 3'b100, 3'b000.
- Accept bin=200, then pulse start with bin=7 at cycle 3 of the conversion; also change bin to 0 -> only one done; bcd=12'h200; the second start is not queued.
- Assert reset at cycle 4 of a bin=123 conversion -> next cycle busy=0, done=0, bcd=0; no done pulse follows. A new start with bin=123 then yields 12'h123.
- start held high with bin stepping 0..255 every accept -> done every 9 cycles; each bcd equals the decimal of the captured bin (exhaustive compare against a reference model).
- Prior result 12'h042 stays stable on bcd for the whole next conversion until its done edge.

Source files
------------

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential binary-to-BCD converter (iterative shift-and-add-3).
//            Converts one WIDTH-bit value per accepted start into DIGITS
//            BCD nibbles, one iteration per clock, WIDTH iterations total.
// Options  : `define LEADING_ZERO_BLANK_EN adds a registered per-digit
//            leading-zero blanking output (blank).
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef LEADING_ZERO_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
  function automatic bit range_ok();
    logic [127:0] p;
    p = 128'd1;
    for (int i = 0; i < DIGITS; i++) p = p * 128'd10;
    return p > ((128'd1 << WIDTH) - 128'd1);
  endfunction

  localparam bit RANGE_OK = range_ok();

  if (!RANGE_OK) begin : g_bad_params
    $error("bin2bcd_seq: DIGITS too small for WIDTH (need 10^DIGITS > 2^WIDTH-1)");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     shift_q;
  logic [4*DIGITS-1:0]  scratch_q;
  logic [CW-1:0]        cnt_q;
  logic [4*DIGITS-1:0]  bcd_q;
  logic                 busy_q;
  logic                 done_q;

  // Add-3 corrected scratch, and the next-iteration scratch/shift values.
  logic [4*DIGITS-1:0]  adj;
  logic [4*DIGITS-1:0]  scratch_d;
  logic [WIDTH-1:0]     shift_d;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    logic [3:0] dig;
    assign dig            = scratch_q[4*gi +: 4];
    assign adj[4*gi +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
  end

  // One shift of {scratch, shift register}; the scratch MSB never carries a
  // set bit because the digit count covers the full input range.
  assign scratch_d = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
  assign shift_d   = shift_q << 1;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] dzero;
  logic [DIGITS-1:0] hz;
  logic [DIGITS-1:0] blank_d;
  logic [DIGITS-1:0] blank_q;

  // hz[i]: digit i and every higher digit of the finished result are zero.
  for (genvar gb = 0; gb < DIGITS; gb++) begin : g_blank
    assign dzero[gb] = (scratch_d[4*gb +: 4] == 4'd0);
    if (gb == DIGITS - 1) begin : g_top
      assign hz[gb] = dzero[gb];
    end else begin : g_chain
      assign hz[gb] = dzero[gb] & hz[gb+1];
    end
    if (gb == 0) begin : g_lsd
      assign blank_d[gb] = 1'b0;
    end else begin : g_upper
      assign blank_d[gb] = hz[gb];
    end
  end

  assign blank = blank_q;
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= bin;
            scratch_q <= '0;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q   <= scratch_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q <= blank_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Purpose  : Self-checking bench for bin2bcd_seq with a cycle model and an
//            expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic                 mclk;
  logic                 reset;
  logic                 start;
  logic [WIDTH-1:0]     bin;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  bcd;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]    blank;
`endif

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .mclk  (mclk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
`ifdef LEADING_ZERO_BLANK_EN
    ,
    .blank (blank)
`endif
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int errs   = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Decimal reference conversion by repeated division.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] to_blank(input logic [4*DIGITS-1:0] b);
    logic [DIGITS-1:0] r;
    r = '0;
    for (int i = 1; i < DIGITS; i++) r[i] = ((b >> (4*i)) == '0);
    return r;
  endfunction

  // Scoreboard and cycle-level reference state.
  logic [4*DIGITS-1:0] exp_q[$];
  int                  m_cnt = 0;
  logic                m_done = 1'b0;
  logic [4*DIGITS-1:0] m_bcd = '0;
  int                  cyc = 0;
  int                  acc_cyc = 0;
  int                  last_done_cyc = 0;
  bit                  gap_check = 1'b0;
  bit                  gap_valid = 1'b0;

  // Monitor: sample inputs at the edge, advance the model, compare #1 later.
  initial begin
    logic                s_start, s_reset;
    logic [WIDTH-1:0]    s_bin;
    forever begin
      @(posedge mclk);
      s_start = start;
      s_reset = reset;
      s_bin   = bin;
      cyc++;
      #1;
      m_done = 1'b0;
      if (s_reset) begin
        m_cnt = 0;
        m_bcd = '0;
        exp_q.delete();
      end else if (m_cnt == 0) begin
        if (s_start) begin
          exp_q.push_back(to_bcd(int'(s_bin)));
          m_cnt   = WIDTH;
          acc_cyc = cyc;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_bcd  = exp_q.pop_front();
          check_eq("latency", cyc - acc_cyc, WIDTH);
          if (gap_check && gap_valid) check_eq("gap", cyc - last_done_cyc, WIDTH + 1);
          gap_valid     = gap_check;
          last_done_cyc = cyc;
        end
      end
      check_eq("busy", busy, (m_cnt != 0));
      check_eq("done", done, m_done);
      check_eq("bcd", bcd, m_bcd);
`ifdef LEADING_ZERO_BLANK_EN
      check_eq("blank", blank, (s_reset ? '0 : to_blank(m_bcd)));
`endif
    end
  end

  task automatic convert(input int v);
    @(negedge mclk);
    bin   = WIDTH'(v);
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    repeat (WIDTH + 1) @(negedge mclk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(negedge mclk);
    reset = 1'b0;

    // Basic conversions, including zero and digit-rollover boundaries.
    convert(255);
    convert(0);
    convert(99);
    convert(100);
    convert(42);

    // Start and bin changes during a conversion are ignored; 042 stays
    // on bcd until the 200 result completes.
    @(negedge mclk);
    bin   = 8'd200;
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    repeat (2) @(negedge mclk);
    bin   = 8'd7;
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    bin   = 8'd0;
    repeat (WIDTH + 2) @(negedge mclk);

    // Reset part-way through a conversion aborts it without a done pulse.
    bin   = 8'd123;
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    repeat (3) @(negedge mclk);
    reset = 1'b1;
    @(negedge mclk);
    reset = 1'b0;
    repeat (WIDTH + 3) @(negedge mclk);
    convert(123);

    // start held high: one accept every WIDTH+1 cycles, bin stepped per accept.
    gap_check = 1'b1;
    gap_valid = 1'b0;
    start     = 1'b1;
    for (int v = 0; v < 256; v++) begin
      bin = WIDTH'(v);
      repeat (WIDTH + 1) @(negedge mclk);
    end
    start = 1'b0;
    repeat (WIDTH + 3) @(negedge mclk);
    gap_check = 1'b0;

    check_eq("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
